// File: rtl/dm_display_reader.sv
// Periodically mirrors a window of data memory into a shadow buffer and serves LCD slot polls.
// Optional build macro DM_READER_TIMEOUT_EN adds a 16-cycle read timeout with sticky timeout_err.
module dm_display_reader #(
  parameter int          NUM_WORDS   = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0020,
  parameter int          REFRESH_DIV = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        snap_req,
  output logic        dm_req,
  input  logic        dm_gnt,
  output logic [31:0] dm_addr,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic        scan_busy,
  output logic        timeout_err,
  input  logic [5:0]  display_number,
  output logic        display_valid,
  output logic [39:0] display_name,
  output logic [31:0] display_value,
  output logic [1:0]  dbg_state
);

  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            pending_q, pending_d;
  logic [CW-1:0]   ref_cnt_q;
  logic            tick, trigger, to_fire, wr_en;
  logic [31:0]     wr_data;
  logic [31:0]     shadow_q [NUM_WORDS];

  assign tick    = (ref_cnt_q == CW'(REFRESH_DIV - 1));
  assign trigger = tick | snap_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ref_cnt_q <= '0;
    else       ref_cnt_q <= tick ? '0 : ref_cnt_q + CW'(1);
  end

  // Read handshake: dm_req/dm_addr hold in REQ until dm_gnt is seen high on an edge;
  // the data beat is the first dm_rvalid seen in WAIT, rvalid anywhere else is dropped.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    wr_en     = 1'b0;
    wr_data   = dm_rvalid ? dm_rdata : 32'hDEAD_BEEF;
    case (state_q)
      IDLE: begin
        if (pending_q || trigger) begin
          state_d   = REQ;
          idx_d     = '0;
          pending_d = 1'b0;
        end
      end
      REQ: begin
        if (trigger) pending_d = 1'b1;
        if (dm_gnt)  state_d   = WAIT;
      end
      WAIT: begin
        if (trigger) pending_d = 1'b1;
        if (dm_rvalid || to_fire) begin
          wr_en = 1'b1;
          if (idx_q == IW'(NUM_WORDS - 1)) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
    end
  end

`ifdef DM_READER_TIMEOUT_EN
  logic [3:0] wait_cnt_q;
  logic       timeout_err_q;

  assign to_fire     = (state_q == WAIT) && !dm_rvalid && (wait_cnt_q == 4'hF);
  assign timeout_err = timeout_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q    <= 4'd0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == WAIT) ? wait_cnt_q + 4'd1 : 4'd0;
      if (to_fire) timeout_err_q <= 1'b1;
    end
  end
`else
  assign to_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_WORDS; k++) shadow_q[k] <= '0;
    end else if (wr_en) begin
      shadow_q[idx_q] <= wr_data;
    end
  end

  assign dm_req    = (state_q == REQ);
  assign dm_addr   = dm_req ? BASE_ADDR + (32'(idx_q) << 2) : 32'h0;
  assign scan_busy = (state_q != IDLE);
  assign dbg_state = state_q;

  function automatic logic [7:0] hex_char(input logic [3:0] v);
    return (v < 4'd10) ? 8'h30 + {4'h0, v} : 8'h37 + {4'h0, v};
  endfunction

  logic [5:0]  slot;
  logic        hit;
  logic [39:0] name_d;

  always_comb begin
    slot   = display_number - 6'd1;
    hit    = (display_number != 6'd0) && (display_number <= 6'(NUM_WORDS));
    name_d = {8'h44, 8'h4D, 8'h5F, hex_char({2'b00, slot[5:4]}), hex_char(slot[3:0])};
  end

  // Registered poll: a same-edge shadow write is seen on the following poll.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      display_valid <= 1'b0;
      display_name  <= '0;
      display_value <= '0;
    end else begin
      display_valid <= hit;
      display_name  <= hit ? name_d : '0;
      display_value <= hit ? shadow_q[slot[IW-1:0]] : '0;
    end
  end

endmodule

// File: tb/tb_dm_display_reader.sv
// Randomized bench for dm_display_reader with a memory responder and a shadow-buffer reference.
module tb_dm_display_reader;
  localparam int          NW   = 8;
  localparam logic [31:0] BASE = 32'h0000_0020;
  localparam int          RD   = 700;

  logic        clk, reset, snap_req, dm_req, dm_gnt, dm_rvalid, scan_busy, timeout_err;
  logic [31:0] dm_addr, dm_rdata, display_value;
  logic [5:0]  display_number;
  logic        display_valid;
  logic [39:0] display_name;
  logic [1:0]  dbg_state;

  dm_display_reader #(.NUM_WORDS(NW), .BASE_ADDR(BASE), .REFRESH_DIV(RD)) dut (
    .clk(clk), .reset(reset), .snap_req(snap_req), .dm_req(dm_req), .dm_gnt(dm_gnt),
    .dm_addr(dm_addr), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .scan_busy(scan_busy),
    .timeout_err(timeout_err), .display_number(display_number), .display_valid(display_valid),
    .display_name(display_name), .display_value(display_value), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [NW];
  logic [31:0] exp_shadow [NW];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  int          n_grants = 0;
  int          resp_limit = 1000000;
  bit          junk_en = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got no end, required end");
    $fatal(1);
  end

  // Memory responder: one-cycle read latency after each grant.
  initial begin
    logic        grab, junk;
    logic [31:0] gaddr;
    int          ix;
    dm_rvalid = 0;
    dm_rdata  = 0;
    forever begin
      @(negedge clk);
      grab = 0;
      gaddr = 0;
      if (dm_req && dm_gnt) begin
        grab  = (n_grants < resp_limit);
        gaddr = dm_addr;
        got_q.push_back(dm_addr);
        n_grants++;
      end
      junk = dm_req && !dm_gnt && junk_en;
      @(posedge clk);
      #1;
      if (grab) begin
        ix = int'((gaddr - BASE) >> 2);
        dm_rvalid = 1;
        dm_rdata  = (ix >= 0 && ix < NW) ? mem[ix] : 32'hBAD0_0000;
      end else begin
        dm_rvalid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        dm_rdata  = $urandom;
      end
    end
  end

  function automatic logic [39:0] exp_name(input int n);
    logic [39:0] r;
    string s;
    r = '0;
    if (n >= 1 && n <= NW) begin
      s = $sformatf("DM_%02X", n - 1);
      for (int k = 0; k < 5; k++) r[39-8*k -: 8] = s[k];
    end
    return r;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1;
    snap_req = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    for (int k = 0; k < NW; k++) exp_shadow[k] = '0;
    got_q.delete();
  endtask

  task automatic pulse_snap();
    @(posedge clk); #1 snap_req = 1;
    @(posedge clk); #1 snap_req = 0;
  endtask

  task automatic wait_idle(input int budget, output int cyc, output bit ok);
    cyc = 0;
    ok  = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      cyc++;
      if (!scan_busy) begin ok = 1; break; end
    end
  endtask

  task automatic read_slot(input int n, output logic vld, output logic [39:0] nm,
                           output logic [31:0] val);
    @(posedge clk); #1 display_number = 6'(n);
    @(posedge clk);
    @(negedge clk);
    vld = display_valid;
    nm  = display_name;
    val = display_value;
  endtask

  task automatic check_all_slots(input string tag);
    logic vld; logic [39:0] nm; logic [31:0] val;
    for (int n = 1; n <= NW; n++) begin
      read_slot(n, vld, nm, val);
      checks++;
      if (vld !== 1'b1 || nm !== exp_name(n) || val !== exp_shadow[n-1]) begin
        failures++;
        $display("FAIL %s slot %0d: got v=%b name=%h val=%h, required v=1 name=%h val=%h",
                 tag, n, vld, nm, val, exp_name(n), exp_shadow[n-1]);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({dm_req, scan_busy, timeout_err, display_valid} !== 4'b0 || dm_addr !== 32'h0 ||
        display_name !== 40'h0 || display_value !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%b busy=%b to=%b v=%b addr=%h name=%h val=%h, required all 0",
               dm_req, scan_busy, timeout_err, display_valid, dm_addr, display_name, display_value);
    end
    @(posedge clk); #1 reset = 0;
    for (int k = 0; k < NW; k++) exp_shadow[k] = '0;
    check_all_slots("reset_shadow");
  endtask

  task automatic test_scan();
    int cyc; bit ok;
    do_reset();
    dm_gnt = 1;
    for (int it = 0; it < 2; it++) begin
      for (int k = 0; k < NW; k++) mem[k] = (it == 0) ? 32'(k * 32'h11) : $urandom;
      got_q.delete();
      exp_q.delete();
      for (int k = 0; k < NW; k++) exp_q.push_back(BASE + 32'(4 * k));
      pulse_snap();
      @(negedge clk);
      checks++;
      if (scan_busy !== 1'b1) begin
        failures++;
        $display("FAIL scan_start: got busy=%b, required 1", scan_busy);
      end
      wait_idle(200, cyc, ok);
      checks++;
      if (!ok || cyc != 2 * NW) begin
        failures++;
        $display("FAIL scan_time: got %0d cycles (done=%0b), required %0d", cyc, ok, 2 * NW);
      end
      checks++;
      if (got_q.size() != NW) begin
        failures++;
        $display("FAIL scan_reqs: got %0d grants, required %0d", got_q.size(), NW);
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
        logic [31:0] e, g;
        e = exp_q.pop_front();
        g = got_q.pop_front();
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL scan_addr: got %h, required %h", g, e);
        end
      end
      for (int k = 0; k < NW; k++) exp_shadow[k] = mem[k];
      check_all_slots("scan_data");
    end
  endtask

  task automatic test_grant_stall();
    int cyc, n, prev; bit ok;
    for (int k = 0; k < NW; k++) mem[k] = $urandom;
    dm_gnt = 0;
    junk_en = 1;
    prev = 0;
    pulse_snap();
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      n = $urandom_range(1, NW);
      display_number = 6'(n);
      @(negedge clk);
      checks++;
      if (dm_req !== 1'b1 || dm_addr !== BASE) begin
        failures++;
        $display("FAIL stall_req: got req=%b addr=%h, required req=1 addr=%h", dm_req, dm_addr, BASE);
      end
      if (prev != 0) begin
        checks++;
        if (display_value !== exp_shadow[prev-1]) begin
          failures++;
          $display("FAIL stall_shadow slot %0d: got %h, required %h", prev, display_value, exp_shadow[prev-1]);
        end
      end
      prev = n;
    end
    @(posedge clk); #1;
    dm_gnt = 1;
    junk_en = 0;
    wait_idle(200, cyc, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_release: got busy=1 after %0d cycles, required scan done", cyc);
    end
    for (int k = 0; k < NW; k++) exp_shadow[k] = mem[k];
    check_all_slots("stall_data");
  endtask

  task automatic test_display();
    int list [4] = '{0, 9, 44, 8};
    int n, prev;
    prev = int'(display_number);
    for (int it = 0; it < 24; it++) begin
      n = (it < 4) ? list[it] : (($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, NW + 1));
      @(posedge clk); #1 display_number = 6'(n);
      @(negedge clk);
      checks++;
      if (display_valid !== ((prev >= 1 && prev <= NW) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL display_latency n=%0d: got v=%b early, required previous poll result", n, display_valid);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (n >= 1 && n <= NW) begin
        if (display_valid !== 1'b1 || display_name !== exp_name(n) || display_value !== exp_shadow[n-1]) begin
          failures++;
          $display("FAIL display_decode n=%0d: got v=%b name=%h val=%h, required v=1 name=%h val=%h",
                   n, display_valid, display_name, display_value, exp_name(n), exp_shadow[n-1]);
        end
      end else if (display_valid !== 1'b0 || display_name !== 40'h0 || display_value !== 32'h0) begin
        failures++;
        $display("FAIL display_out_of_range n=%0d: got v=%b name=%h val=%h, required all 0",
                 n, display_valid, display_name, display_value);
      end
      prev = n;
    end
  endtask

  task automatic test_collapse();
    int cyc; bit ok;
    do_reset();
    dm_gnt = 1;
    for (int k = 0; k < NW; k++) mem[k] = $urandom;
    n_grants = 0;
    pulse_snap();
    for (int p = 0; p < 3; p++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      pulse_snap();
    end
    wait_idle(200, cyc, ok);
    @(negedge clk);
    checks++;
    if (!ok || scan_busy !== 1'b1) begin
      failures++;
      $display("FAIL collapse_rescan: got busy=%b (first done=%0b), required second scan running", scan_busy, ok);
    end
    wait_idle(200, cyc, ok);
    repeat (40) @(negedge clk);
    checks++;
    if (n_grants != 2 * NW || scan_busy !== 1'b0) begin
      failures++;
      $display("FAIL collapse_count: got %0d grants busy=%b, required %0d grants busy=0", n_grants, scan_busy, 2 * NW);
    end
    for (int k = 0; k < NW; k++) exp_shadow[k] = mem[k];
    check_all_slots("collapse_data");
  endtask

  task automatic test_reset_mid();
    int guard; logic vld; logic [39:0] nm; logic [31:0] val;
    do_reset();
    dm_gnt = 1;
    for (int k = 0; k < NW; k++) mem[k] = $urandom | 32'h1;
    resp_limit = 4;
    n_grants = 0;
    pulse_snap();
    guard = 0;
    while (n_grants < 5 && guard < 200) begin @(negedge clk); guard++; end
    read_slot(1, vld, nm, val);
    checks++;
    if (val !== mem[0] || scan_busy !== 1'b1 || dm_req !== 1'b0) begin
      failures++;
      $display("FAIL midscan_state: got slot1=%h busy=%b req=%b, required slot1=%h busy=1 req=0",
               val, scan_busy, dm_req, mem[0]);
    end
    @(posedge clk); #2 reset = 1;
    #1;
    checks++;
    if (dm_req !== 1'b0 || scan_busy !== 1'b0 || dm_addr !== 32'h0) begin
      failures++;
      $display("FAIL midscan_async: got req=%b busy=%b addr=%h, required 0/0/0", dm_req, scan_busy, dm_addr);
    end
    repeat (2) @(posedge clk);
    #1 reset = 0;
    resp_limit = 1000000;
    for (int k = 0; k < NW; k++) exp_shadow[k] = '0;
    check_all_slots("midscan_cleared");
  endtask

  task automatic test_timeout();
    int cyc; bit ok;
    do_reset();
    dm_gnt = 1;
    resp_limit = 0;
    n_grants = 0;
    pulse_snap();
`ifdef DM_READER_TIMEOUT_EN
    @(negedge clk);
    wait_idle(400, cyc, ok);
    checks++;
    if (!ok || cyc != 17 * NW || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_scan: got %0d cycles done=%0b err=%b, required %0d cycles err=1",
               cyc, ok, timeout_err, 17 * NW);
    end
    for (int k = 0; k < NW; k++) exp_shadow[k] = 32'hDEAD_BEEF;
    check_all_slots("timeout_data");
`else
    repeat (100) @(negedge clk);
    checks++;
    if (scan_busy !== 1'b1 || timeout_err !== 1'b0 || n_grants != 1) begin
      failures++;
      $display("FAIL wait_forever: got busy=%b err=%b grants=%0d, required busy=1 err=0 grants=1",
               scan_busy, timeout_err, n_grants);
    end
    cyc = 0; ok = 0;
`endif
    resp_limit = 1000000;
    do_reset();
  endtask

  task automatic test_tick();
    int cyc; bit ok;
    do_reset();
    dm_gnt = 1;
    for (int k = 0; k < NW; k++) mem[k] = $urandom;
    repeat (RD - 1) @(posedge clk);
    @(negedge clk);
    checks++;
    if (scan_busy !== 1'b0) begin
      failures++;
      $display("FAIL tick_early: got busy=%b at cycle %0d, required 0", scan_busy, RD - 1);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (scan_busy !== 1'b1) begin
      failures++;
      $display("FAIL tick_start: got busy=%b at cycle %0d, required 1", scan_busy, RD);
    end
    wait_idle(200, cyc, ok);
    for (int k = 0; k < NW; k++) exp_shadow[k] = mem[k];
    check_all_slots("tick_data");
  endtask

  initial begin
    reset = 1;
    snap_req = 0;
    dm_gnt = 0;
    display_number = 0;
    test_reset();
    test_scan();
    test_grant_stall();
    test_display();
    test_collapse();
    test_reset_mid();
    test_timeout();
    test_tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
